// File: rtl/reg_wr_arbiter_if.sv
// Register-file write-port bundle: two requesters (A = ALU writeback, B = load unit)
// plus the registered write enables/data and the debug conflict count.
interface reg_wr_arbiter_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic                a_req;
    logic [ADDR_W-1:0]   a_addr;
    logic [DATA_W-1:0]   a_data;
    logic                a_gnt;
    logic                b_req;
    logic [ADDR_W-1:0]   b_addr;
    logic [DATA_W-1:0]   b_data;
    logic                b_gnt;
    logic [NUM_REGS-1:0] wen;
    logic [DATA_W-1:0]   wdata;
    logic [CNT_W-1:0]    conflict_cnt;

    modport master (
        output a_req, a_addr, a_data, b_req, b_addr, b_data,
        input  a_gnt, b_gnt, wen, wdata, conflict_cnt
    );

    modport slave (
        input  a_req, a_addr, a_data, b_req, b_addr, b_data,
        output a_gnt, b_gnt, wen, wdata, conflict_cnt
    );
endinterface

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port; combinational grants,
// registered one-hot wen/wdata one cycle later; a loser is held off by withholding its gnt.
module reg_wr_arbiter #(
    parameter int DATA_W  = 10,
    parameter int ADDR_W  = 3,
    parameter int ZERO_RO = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    reg_wr_arbiter_if.slave  bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    prio_e               prio_q, prio_d;
    logic [NUM_REGS-1:0] wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                a_gnt, b_gnt, any_gnt, conflict;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    // Grants look only at the requests and prio, never at addr/data.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            if (bus.a_req && (!bus.b_req || prio_q == PRIO_A)) begin
                a_gnt = 1'b1;
            end else if (bus.b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    assign any_gnt  = a_gnt || b_gnt;
    assign conflict = bus.a_req && bus.b_req;
    assign sel_addr = b_gnt ? bus.b_addr : bus.a_addr;
    assign sel_data = b_gnt ? bus.b_data : bus.a_data;

    always_comb begin
        prio_d  = prio_q;
        wen_d   = '0;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;

        if (a_gnt) begin
            prio_d = PRIO_B;
        end else if (b_gnt) begin
            prio_d = PRIO_A;
        end

        // Register 0 is hardwired when ZERO_RO: the grant is consumed but nothing is written.
        if (any_gnt && !(ZERO_RO != 0 && sel_addr == '0)) begin
            wen_d   = NUM_REGS'(1) << sel_addr;
            wdata_d = sel_data;
        end

        if (conflict && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q  <= PRIO_A;
            wen_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            prio_q  <= prio_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.a_gnt        = a_gnt;
    assign bus.b_gnt        = b_gnt;
    assign bus.wen          = wen_q;
    assign bus.wdata        = wdata_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Scoreboard bench for reg_wr_arbiter: directed scenarios followed by random requester traffic.
module tb_reg_wr_arbiter;
    localparam int DW = 10;
    localparam int AW = 3;
    localparam int CW = 8;
    localparam int NR = 2 ** AW;

    typedef struct {
        int   cyc;
        logic ga;
        logic gb;
    } gnt_exp_t;

    typedef struct {
        int            cyc;
        logic [NR-1:0] wen;
        logic [DW-1:0] wdata;
        logic [CW-1:0] cnt;
    } out_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reg_wr_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    reg_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ZERO_RO(1), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    gnt_exp_t gnt_q[$];
    out_exp_t out_q[$];
    int cyc    = -1;
    int checks = 0;
    int errors = 0;

    // Reference model state: who goes first on a tie, last written data, conflict count.
    bit            m_b_first;
    logic [DW-1:0] m_wdata;
    int            m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One bus cycle: drive inputs just after the edge, predict grants now and outputs next cycle.
    task automatic step(input logic r,
                        input logic ar, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic br, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                        output logic ga, output logic gb);
        gnt_exp_t ge;
        out_exp_t oe;
        logic [AW-1:0] wa;
        @(posedge clk);
        #1;
        rst        = r;
        bus.a_req  = ar;
        bus.a_addr = aa;
        bus.a_data = ad;
        bus.b_req  = br;
        bus.b_addr = ba;
        bus.b_data = bd;
        cyc        = cyc + 1;

        oe.wen = '0;
        if (r) begin
            ga        = 1'b0;
            gb        = 1'b0;
            m_b_first = 1'b0;
            m_wdata   = '0;
            m_cnt     = 0;
        end else begin
            if (ar && br) begin
                ga = !m_b_first;
                gb = m_b_first;
                m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            end else begin
                ga = ar;
                gb = br;
            end
            if (ga || gb) begin
                wa        = ga ? aa : ba;
                m_b_first = ga;
                if (wa != 0) begin
                    oe.wen[wa] = 1'b1;
                    m_wdata    = ga ? ad : bd;
                end
            end
        end
        ge.cyc   = cyc;
        ge.ga    = ga;
        ge.gb    = gb;
        oe.cyc   = cyc + 1;
        oe.wdata = m_wdata;
        oe.cnt   = m_cnt[CW-1:0];
        gnt_q.push_back(ge);
        out_q.push_back(oe);
    endtask

    // Monitor: compares whatever the DUT presents mid-cycle against the queued predictions.
    initial begin
        gnt_exp_t ge;
        out_exp_t oe;
        forever begin
            @(negedge clk);
            if (cyc >= 0) begin
                if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
                    ge = gnt_q.pop_front();
                    chk("a_gnt", 32'(bus.a_gnt), 32'(ge.ga));
                    chk("b_gnt", 32'(bus.b_gnt), 32'(ge.gb));
                end
                while (out_q.size() > 0 && out_q[0].cyc < cyc) begin
                    oe = out_q.pop_front();
                    chk("missed_output_slot", 32'(oe.cyc), 32'(cyc));
                end
                if (out_q.size() > 0 && out_q[0].cyc == cyc) begin
                    oe = out_q.pop_front();
                    chk("wen", 32'(bus.wen), 32'(oe.wen));
                    chk("wdata", 32'(bus.wdata), 32'(oe.wdata));
                    chk("conflict_cnt", 32'(bus.conflict_cnt), 32'(oe.cnt));
                end
                if (cyc >= 1) begin
                    chk("wen_onehot0", 32'($onehot0(bus.wen)), 32'd1);
                    chk("gnt_exclusive", 32'(bus.a_gnt && bus.b_gnt), 32'd0);
                end
            end
        end
    end

    initial begin
        logic ga, gb;
        bit a_pend, b_pend;
        logic [AW-1:0] a_ad, b_ad;
        logic [DW-1:0] a_dt, b_dt;

        bus.a_req  = 1'b0;
        bus.a_addr = '0;
        bus.a_data = '0;
        bus.b_req  = 1'b0;
        bus.b_addr = '0;
        bus.b_data = '0;

        // Reset held two cycles with both requesting.
        step(1, 1, 3'd5, 10'h3FF, 1, 3'd6, 10'h155, ga, gb);
        step(1, 1, 3'd5, 10'h3FF, 1, 3'd6, 10'h155, ga, gb);
        // Single write A -> r3, then an idle cycle so the wen pulse is seen to drop.
        step(0, 1, 3'd3, 10'h2A5, 0, 3'd0, 10'h000, ga, gb);
        step(0, 0, 3'd0, 10'h000, 0, 3'd0, 10'h000, ga, gb);
        step(0, 0, 3'd0, 10'h000, 0, 3'd0, 10'h000, ga, gb);
        // Round-robin from a fresh reset.
        step(1, 0, 3'd0, 10'h000, 0, 3'd0, 10'h000, ga, gb);
        step(0, 1, 3'd1, 10'h001, 1, 3'd2, 10'h002, ga, gb);
        step(0, 1, 3'd1, 10'h001, 1, 3'd2, 10'h002, ga, gb);
        step(0, 0, 3'd0, 10'h000, 0, 3'd0, 10'h000, ga, gb);
        // A write moves priority to B; B writing r0 is granted but silent and hands priority back.
        step(0, 1, 3'd7, 10'h0F0, 0, 3'd0, 10'h000, ga, gb);
        step(0, 0, 3'd0, 10'h000, 1, 3'd0, 10'h3C3, ga, gb);
        step(0, 1, 3'd5, 10'h155, 1, 3'd6, 10'h0AA, ga, gb);
        step(0, 0, 3'd0, 10'h000, 1, 3'd6, 10'h0AA, ga, gb);
        step(0, 0, 3'd0, 10'h000, 0, 3'd0, 10'h000, ga, gb);
        // Same address from both sides.
        step(0, 1, 3'd4, 10'h111, 1, 3'd4, 10'h222, ga, gb);
        step(0, 0, 3'd4, 10'h111, 1, 3'd4, 10'h222, ga, gb);
        // Saturation: both requesting for 300 cycles.
        for (int i = 0; i < 300; i++) begin
            step(0, 1, AW'($urandom_range(0, NR - 1)), DW'($urandom),
                 1, AW'($urandom_range(0, NR - 1)), DW'($urandom), ga, gb);
        end
        // Reset landing on a cycle where A would have been granted.
        step(0, 1, 3'd2, 10'h0CC, 0, 3'd0, 10'h000, ga, gb);
        step(1, 1, 3'd4, 10'h3FF, 0, 3'd0, 10'h000, ga, gb);
        step(0, 1, 3'd2, 10'h0CC, 1, 3'd3, 10'h033, ga, gb);
        step(0, 0, 3'd0, 10'h000, 1, 3'd3, 10'h033, ga, gb);

        // Random requesters that hold their request until granted.
        a_pend = 1'b0;
        b_pend = 1'b0;
        a_ad = '0; a_dt = '0; b_ad = '0; b_dt = '0;
        for (int i = 0; i < 600; i++) begin
            if (!a_pend && $urandom_range(0, 2) != 0) begin
                a_pend = 1'b1;
                a_ad   = AW'($urandom_range(0, NR - 1));
                a_dt   = DW'($urandom);
            end
            if (!b_pend && $urandom_range(0, 2) != 0) begin
                b_pend = 1'b1;
                b_ad   = AW'($urandom_range(0, NR - 1));
                b_dt   = DW'($urandom);
            end
            step(($urandom_range(0, 63) == 0), a_pend, a_ad, a_dt, b_pend, b_ad, b_dt, ga, gb);
            if (ga) a_pend = 1'b0;
            if (gb) b_pend = 1'b0;
        end

        for (int i = 0; i < 3; i++) begin
            step(0, 0, 3'd0, 10'h000, 0, 3'd0, 10'h000, ga, gb);
        end
        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
